wb_port_arbiter: RTL and testbench

Write-port arbiter and scheduler for the register file's single write port. It sits after the EXMEM/WB stage register and shares the port between two sources: the in-order pipeline writeback and a multi-cycle execution unit (multiplier/divider) that returns results out of band. Multi-cycle results wait in a 2-entry holding FIFO. The block enforces write-after-write ordering and requests a front-end bubble when a held result has been starved too long.

---
 rtl/wb_port_arbiter.sv | 119 +++++++++++
 tb/tb_wb_port_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. multi-cycle results
// held in a 2-entry FIFO, with WAW squash and a starvation-driven front-end hold.
module wb_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WB_Wreg_en,
  input  logic [4:0]  WB_Wreg,
  input  logic [63:0] WB_data,
  input  logic [2:0]  WB_ppp,
  input  logic        MC_valid,
  output logic        MC_ready,
  input  logic [4:0]  MC_Wreg,
  input  logic [63:0] MC_data,
  input  logic [2:0]  MC_ppp,
  output logic        RF_we,
  output logic [4:0]  RF_waddr,
  output logic [63:0] RF_wdata,
  output logic [2:0]  RF_ppp,
  output logic        hold,
  output logic [1:0]  pend_cnt
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef struct packed {
    logic        valid;
    logic        squash;
    logic [4:0]  wreg;
    logic [63:0] data;
    logic [2:0]  ppp;
  } entry_t;

  // Slot 0 is always the head; valid bits stay contiguous from slot 0.
  entry_t     fifo_q [2];
  entry_t     fifo_d [2];
  entry_t     upd    [2];
  entry_t     new_e;
  logic [3:0] starve_q;
  logic [3:0] starve_d;
  logic       waw;
  logic       push;
  logic       pop;
  logic       head_write;

  assign pend_cnt = {fifo_q[1].valid, fifo_q[0].valid & ~fifo_q[1].valid};
  assign MC_ready = (pend_cnt < 2'd2);

  always_comb begin
    waw        = WB_Wreg_en && (WB_ppp == 3'b000);
    push       = MC_valid && MC_ready;
    head_write = fifo_q[0].valid && !fifo_q[0].squash && !WB_Wreg_en;
    pop        = fifo_q[0].valid && (fifo_q[0].squash || !WB_Wreg_en);

    for (int unsigned i = 0; i < 2; i++) begin
      upd[i] = fifo_q[i];
      if (waw && fifo_q[i].valid && (fifo_q[i].wreg == WB_Wreg))
        upd[i].squash = 1'b1;
    end

    // A same-cycle push counts as older than the pipeline write, so it is squashed too.
    new_e.valid  = 1'b1;
    new_e.squash = waw && (MC_Wreg == WB_Wreg);
    new_e.wreg   = MC_Wreg;
    new_e.data   = MC_data;
    new_e.ppp    = MC_ppp;

    if (pop) begin
      fifo_d[0] = upd[1];
      fifo_d[1] = '0;
    end else begin
      fifo_d[0] = upd[0];
      fifo_d[1] = upd[1];
    end

    if (push) begin
      if (!fifo_d[0].valid) fifo_d[0] = new_e;
      else                  fifo_d[1] = new_e;
    end

    starve_d = starve_q;
    if (pop || !fifo_q[0].valid)
      starve_d = '0;
    else if (!fifo_q[0].squash && WB_Wreg_en && (starve_q != 4'hF))
      starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 2; i++) fifo_q[i] <= '0;
      starve_q <= '0;
      hold     <= 1'b0;
      RF_we    <= 1'b0;
      RF_waddr <= '0;
      RF_wdata <= '0;
      RF_ppp   <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) fifo_q[i] <= fifo_d[i];
      starve_q <= starve_d;
      // Registered off the current count: rises one cycle after the limit, falls one after the pop.
      hold     <= (starve_q >= LIMIT);
      if (WB_Wreg_en) begin
        RF_we    <= 1'b1;
        RF_waddr <= WB_Wreg;
        RF_wdata <= WB_data;
        RF_ppp   <= WB_ppp;
      end else if (head_write) begin
        RF_we    <= 1'b1;
        RF_waddr <= fifo_q[0].wreg;
        RF_wdata <= fifo_q[0].data;
        RF_ppp   <= fifo_q[0].ppp;
      end else begin
        RF_we    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with hand-computed expectations.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        WB_Wreg_en;
  logic [4:0]  WB_Wreg;
  logic [63:0] WB_data;
  logic [2:0]  WB_ppp;
  logic        MC_valid;
  logic        MC_ready;
  logic [4:0]  MC_Wreg;
  logic [63:0] MC_data;
  logic [2:0]  MC_ppp;
  logic        RF_we;
  logic [4:0]  RF_waddr;
  logic [63:0] RF_wdata;
  logic [2:0]  RF_ppp;
  logic        hold;
  logic [1:0]  pend_cnt;

  int errors = 0;
  int checks = 0;

  wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .WB_Wreg_en(WB_Wreg_en), .WB_Wreg(WB_Wreg), .WB_data(WB_data), .WB_ppp(WB_ppp),
    .MC_valid(MC_valid), .MC_ready(MC_ready), .MC_Wreg(MC_Wreg), .MC_data(MC_data),
    .MC_ppp(MC_ppp),
    .RF_we(RF_we), .RF_waddr(RF_waddr), .RF_wdata(RF_wdata), .RF_ppp(RF_ppp),
    .hold(hold), .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic en, input logic [4:0] r, input logic [63:0] d, input logic [2:0] p);
    WB_Wreg_en = en; WB_Wreg = r; WB_data = d; WB_ppp = p;
  endtask

  task automatic mc(input logic v, input logic [4:0] r, input logic [63:0] d, input logic [2:0] p);
    MC_valid = v; MC_Wreg = r; MC_data = d; MC_ppp = p;
  endtask

  initial begin
    rst = 1'b0;
    wb(1'b0, 5'd0, 64'h0, 3'd0);
    mc(1'b0, 5'd0, 64'h0, 3'd0);
    tick();
    tick();
    chk("rst_pend", 64'(pend_cnt), 64'd0);
    chk("rst_ready", 64'(MC_ready), 64'd1);
    chk("rst_we", 64'(RF_we), 64'd0);
    chk("rst_hold", 64'(hold), 64'd0);
    rst = 1'b1;

    // Idle then single MC push
    mc(1'b1, 5'd5, 64'hAA, 3'd0);
    tick();
    mc(1'b0, 5'd0, 64'h0, 3'd0);
    chk("mc1_pend", 64'(pend_cnt), 64'd1);
    chk("mc1_we0", 64'(RF_we), 64'd0);
    tick();
    chk("mc1_we", 64'(RF_we), 64'd1);
    chk("mc1_addr", 64'(RF_waddr), 64'd5);
    chk("mc1_data", RF_wdata, 64'hAA);
    chk("mc1_pend0", 64'(pend_cnt), 64'd0);
    tick();
    chk("mc1_idle_we", 64'(RF_we), 64'd0);
    chk("mc1_keep_addr", 64'(RF_waddr), 64'd5);

    // Pipeline priority while the FIFO fills
    wb(1'b1, 5'd3, 64'h33, 3'd0);
    mc(1'b1, 5'd7, 64'h77, 3'd0);
    tick();
    chk("pri_addr1", 64'(RF_waddr), 64'd3);
    chk("pri_pend1", 64'(pend_cnt), 64'd1);
    mc(1'b1, 5'd8, 64'h88, 3'd0);
    tick();
    chk("pri_pend2", 64'(pend_cnt), 64'd2);
    chk("pri_ready0", 64'(MC_ready), 64'd0);
    mc(1'b1, 5'd11, 64'hBB, 3'd0);
    tick();
    mc(1'b0, 5'd0, 64'h0, 3'd0);
    chk("pri_full_pend", 64'(pend_cnt), 64'd2);
    tick();
    tick();
    chk("pri_hold_early", 64'(hold), 64'd0);
    tick();
    chk("pri_hold", 64'(hold), 64'd1);
    chk("pri_addr6", 64'(RF_waddr), 64'd3);
    chk("pri_we6", 64'(RF_we), 64'd1);
    wb(1'b0, 5'd0, 64'h0, 3'd0);
    tick();
    chk("drain7_addr", 64'(RF_waddr), 64'd7);
    chk("drain7_data", RF_wdata, 64'h77);
    chk("drain7_pend", 64'(pend_cnt), 64'd1);
    chk("drain7_hold", 64'(hold), 64'd1);
    tick();
    chk("drain8_addr", 64'(RF_waddr), 64'd8);
    chk("drain8_data", RF_wdata, 64'h88);
    chk("drain8_hold", 64'(hold), 64'd0);
    chk("drain8_pend", 64'(pend_cnt), 64'd0);
    tick();
    chk("no_third_we", 64'(RF_we), 64'd0);

    // Starvation with one pending entry
    mc(1'b1, 5'd12, 64'hC12, 3'd0);
    tick();
    mc(1'b0, 5'd0, 64'h0, 3'd0);
    wb(1'b1, 5'd4, 64'h44, 3'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("starve_hold4", 64'(hold), 64'd0);
    tick();
    chk("starve_hold5", 64'(hold), 64'd1);
    wb(1'b0, 5'd0, 64'h0, 3'd0);
    tick();
    chk("starve_pop_addr", 64'(RF_waddr), 64'd12);
    chk("starve_pop_hold", 64'(hold), 64'd1);
    tick();
    chk("starve_release", 64'(hold), 64'd0);

    // WAW squash of an older entry
    mc(1'b1, 5'd9, 64'h99, 3'd0);
    tick();
    mc(1'b0, 5'd0, 64'h0, 3'd0);
    wb(1'b1, 5'd9, 64'h5A, 3'd0);
    tick();
    wb(1'b0, 5'd0, 64'h0, 3'd0);
    chk("waw_data", RF_wdata, 64'h5A);
    chk("waw_pend1", 64'(pend_cnt), 64'd1);
    tick();
    chk("waw_drain_we", 64'(RF_we), 64'd0);
    chk("waw_drain_pend", 64'(pend_cnt), 64'd0);
    chk("waw_keep_data", RF_wdata, 64'h5A);

    // Same-cycle push is squashed, then dropped while the pipeline wins
    wb(1'b1, 5'd9, 64'h6B, 3'd0);
    mc(1'b1, 5'd9, 64'h9C, 3'd0);
    tick();
    mc(1'b0, 5'd0, 64'h0, 3'd0);
    wb(1'b1, 5'd2, 64'h22, 3'd0);
    chk("waw2_pend", 64'(pend_cnt), 64'd1);
    tick();
    wb(1'b0, 5'd0, 64'h0, 3'd0);
    chk("waw2_addr", 64'(RF_waddr), 64'd2);
    chk("waw2_pend0", 64'(pend_cnt), 64'd0);
    tick();
    chk("waw2_no_write", 64'(RF_we), 64'd0);

    // Partial-word pipeline write to another register leaves the entry intact
    mc(1'b1, 5'd9, 64'h99, 3'd2);
    tick();
    mc(1'b0, 5'd0, 64'h0, 3'd0);
    wb(1'b1, 5'd10, 64'h10, 3'd1);
    tick();
    wb(1'b0, 5'd0, 64'h0, 3'd0);
    chk("part_ppp", 64'(RF_ppp), 64'd1);
    tick();
    chk("part_addr", 64'(RF_waddr), 64'd9);
    chk("part_data", RF_wdata, 64'h99);
    chk("part_ppp9", 64'(RF_ppp), 64'd2);

    // Asynchronous reset with a full FIFO and hold asserted
    wb(1'b1, 5'd1, 64'h11, 3'd0);
    mc(1'b1, 5'd20, 64'h20, 3'd0);
    tick();
    mc(1'b1, 5'd21, 64'h21, 3'd0);
    tick();
    mc(1'b0, 5'd0, 64'h0, 3'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("pre_rst_pend", 64'(pend_cnt), 64'd2);
    chk("pre_rst_hold", 64'(hold), 64'd1);
    wb(1'b0, 5'd0, 64'h0, 3'd0);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_we", 64'(RF_we), 64'd0);
    chk("arst_hold", 64'(hold), 64'd0);
    chk("arst_pend", 64'(pend_cnt), 64'd0);
    chk("arst_ready", 64'(MC_ready), 64'd1);
    chk("arst_addr", 64'(RF_waddr), 64'd0);
    chk("arst_data", RF_wdata, 64'd0);
    #2;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_we", 64'(RF_we), 64'd0);
      chk("post_rst_pend", 64'(pend_cnt), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
